// File: rtl/seq_muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// seq_muldiv_unit_pkg
// Definitions shared by the ALU and the sequential multiply/divide unit:
//   - FSM state encoding for seq_muldiv_unit
//   - mode encoding of the unit's 'mode' input
//   - ALU opcodes that route an operation to this unit
// -----------------------------------------------------------------------------
package seq_muldiv_unit_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // 'mode' input encoding
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  // ALU opcodes served by this unit
  localparam logic [3:0] MUL = 4'b1010;
  localparam logic [3:0] DIV = 4'b1011;

endpackage

// File: rtl/seq_muldiv_unit.sv
// -----------------------------------------------------------------------------
// seq_muldiv_unit
// Multi-cycle unsigned multiply / divide unit, one result bit per cycle
// (shift-add multiply, restoring divide). One request at a time.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset; aborts any operation
//   valid  in   request strobe, only looked at in IDLE
//   mode   in   0 = multiply, 1 = divide (sampled with valid)
//   in_A   in   multiplicand / dividend (sampled with valid)
//   in_B   in   multiplier / divisor (sampled with valid)
//   ready  out  one-cycle pulse: out holds a new result
//   busy   out  high while a request is in progress (CALC, DONE)
//   out    out  mul: full product; div: {remainder, quotient}
//
// Timing: valid accepted at edge k, ready high in the cycle after edge
// k+WIDTH+1. out holds its value until the next result or reset.
// -----------------------------------------------------------------------------
module seq_muldiv_unit
  import seq_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic               mode,
  input  logic [WIDTH-1:0]   in_A,
  input  logic [WIDTH-1:0]   in_B,
  output logic               ready,
  output logic               busy,
  output logic [2*WIDTH-1:0] out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               mode_q;
  // Operand consumed every iteration: A for multiply, B for divide.
  logic [WIDTH-1:0]   opnd;
  // Shared working register. Multiply: P. Divide: {R, Q} with
  // R = p[2W:W] and Q = p[W-1:0]. Both initialise to {0, operand}
  // and both deliver their result in p[2W-1:0].
  logic [2*WIDTH:0]   p;
  logic [2*WIDTH:0]   p_next;

  // Iteration datapath
  logic [WIDTH:0]     mul_hi;
  logic [WIDTH:0]     r_sh;
  logic [WIDTH+1:0]   trial;

  assign busy = (state != IDLE);

  always_comb begin
    mul_hi = '0;
    r_sh   = '0;
    trial  = '0;
    p_next = p;
    if (mode_q == MODE_DIV) begin
      // Shift {R,Q} left, then try subtracting the divisor. R stays below
      // the divisor, so the shifted R fits in WIDTH+1 bits and the extra
      // top bit of trial is a clean sign bit.
      r_sh  = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
      trial = {1'b0, r_sh} - {2'b00, opnd};
      if (!trial[WIDTH+1])
        p_next = {trial[WIDTH:0], p[WIDTH-2:0], 1'b1};
      else
        p_next = {r_sh, p[WIDTH-2:0], 1'b0};
    end else begin
      // Conditional add into the upper half (carry lands in p[2W]),
      // then shift the whole register right by one.
      mul_hi = p[2*WIDTH:WIDTH] + (p[0] ? {1'b0, opnd} : '0);
      p_next = {1'b0, mul_hi, p[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= MODE_MUL;
      opnd   <= '0;
      p      <= '0;
      out    <= '0;
      ready  <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            mode_q <= mode;
            opnd   <= (mode == MODE_DIV) ? in_B : in_A;
            p      <= {{(WIDTH+1){1'b0}}, (mode == MODE_DIV) ? in_A : in_B};
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          p   <= p_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH-1))
            state <= DONE;
        end
        DONE: begin
          out   <= p[2*WIDTH-1:0];
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_seq_muldiv_unit
// Self-checking bench for seq_muldiv_unit (WIDTH = 32): a table of directed
// vectors with hand-computed results, hand-written sequences for the
// handshake/reset corner cases, and random operations checked against an
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_seq_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic          mode;
  logic [W-1:0]  in_A;
  logic [W-1:0]  in_B;
  logic          ready;
  logic          busy;
  logic [2*W-1:0] out;

  int errors = 0;
  int checks = 0;

  seq_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .mode  (mode),
    .in_A  (in_A),
    .in_B  (in_B),
    .ready (ready),
    .busy  (busy),
    .out   (out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, required finish within 2ms");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic           m;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Unsigned reference: plain product / quotient and remainder, with the
  // RISC-V divide-by-zero convention.
  function automatic logic [2*W-1:0] model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    if (m == 1'b0)       return 64'(a) * 64'(b);
    else if (b == '0)    return {a, {W{1'b1}}};
    else                 return {a % b, a / b};
  endfunction

  // Waits for ready; checks busy stays high and out stays put until then.
  task automatic wait_ready(input string nm, output int edges);
    logic [2*W-1:0] hold;
    logic busy_ok, hold_ok;
    hold = out; busy_ok = 1'b1; hold_ok = 1'b1; edges = 0;
    do begin
      @(posedge clk); #1; edges++;
      if (!ready) begin
        if (!busy) busy_ok = 1'b0;
        if (out !== hold) hold_ok = 1'b0;
      end
    end while (!ready && edges < 200);
    chk({nm, " ready_seen"}, 64'(ready), 64'd1);
    chk({nm, " busy_during"}, 64'(busy_ok), 64'd1);
    chk({nm, " out_hold"}, 64'(hold_ok), 64'd1);
    chk({nm, " busy_at_ready"}, 64'(busy), 64'd0);
  endtask

  task automatic run_op(input string nm, input logic m, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp);
    int edges;
    @(negedge clk);
    valid = 1'b1; mode = m; in_A = a; in_B = b;
    @(posedge clk); #1;
    valid = 1'b0; in_A = $urandom; in_B = $urandom;
    chk({nm, " busy_after_accept"}, 64'(busy), 64'd1);
    wait_ready(nm, edges);
    chk({nm, " latency"}, 64'(edges), 64'(LAT));
    chk({nm, " out"}, out, exp);
    @(posedge clk); #1;
    chk({nm, " ready_pulse_len"}, 64'(ready), 64'd0);
  endtask

  vec_t tbl[10];

  initial begin
    int edges;
    logic rdy_seen;
    logic [W-1:0] ra, rb;
    logic rm;

    tbl[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    tbl[1] = '{1'b1, 32'd100,      32'd7,        64'h00000002_0000000E};
    tbl[2] = '{1'b0, 32'd0,        32'hDEADBEEF, 64'h0};
    tbl[3] = '{1'b1, 32'h12345678, 32'd0,        64'h12345678_FFFFFFFF};
    tbl[4] = '{1'b1, 32'd9,        32'd2,        64'h00000001_00000004};
    tbl[5] = '{1'b0, 32'd3,        32'd5,        64'd15};
    tbl[6] = '{1'b1, 32'd5,        32'd10,       64'h00000005_00000000};
    tbl[7] = '{1'b0, 32'h00010000, 32'h00010000, 64'h00000001_00000000};
    tbl[8] = '{1'b1, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF};
    tbl[9] = '{1'b1, 32'd0,        32'd0,        64'h00000000_FFFFFFFF};

    rst = 1'b1; valid = 1'b0; mode = 1'b0; in_A = '0; in_B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset busy",  64'(busy),  64'd0);
    chk("reset out",   out,        64'd0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].exp);

    // Held valid with new operands: ignored during CALC/DONE, accepted
    // in the ready cycle, completes 34 edges after the first ready.
    @(negedge clk);
    valid = 1'b1; mode = 1'b1; in_A = 32'd100; in_B = 32'd7;
    @(posedge clk); #1;
    mode = 1'b0; in_A = 32'd3; in_B = 32'd5;
    wait_ready("held_first", edges);
    chk("held_first latency", 64'(edges), 64'(LAT));
    chk("held_first out", out, 64'h00000002_0000000E);
    wait_ready("held_second", edges);
    valid = 1'b0;
    chk("held_second latency", 64'(edges), 64'(LAT + 1));
    chk("held_second out", out, 64'd15);
    @(posedge clk); #1;
    chk("held idle after", 64'(busy), 64'd0);

    // Reset in the middle of CALC (counter = 10)
    @(negedge clk);
    valid = 1'b1; mode = 1'b0; in_A = 32'hFFFFFFFF; in_B = 32'hFFFFFFFF;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("abort busy",  64'(busy),  64'd0);
    chk("abort ready", 64'(ready), 64'd0);
    chk("abort out",   out,        64'd0);
    rdy_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready || busy) rdy_seen = 1'b1;
    end
    chk("abort no_ready", 64'(rdy_seen), 64'd0);
    run_op("after_abort", 1'b1, 32'd9, 32'd2, 64'h00000001_00000004);

    // Back-to-back: second request raised the cycle after ready
    run_op("b2b_mul", 1'b0, 32'd2, 32'd3, 64'd6);
    valid = 1'b1; mode = 1'b1; in_A = 32'd7; in_B = 32'd2;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("b2b out_before", out, 64'd6);
    wait_ready("b2b_div", edges);
    chk("b2b_div latency", 64'(edges), 64'(LAT));
    chk("b2b_div out", out, 64'h00000001_00000003);

    // Random operations against the reference model
    for (int i = 0; i < 24; i++) begin
      rm = 1'($urandom);
      ra = $urandom;
      case (i % 4)
        0:       rb = $urandom;
        1:       rb = $urandom_range(0, 255);
        2:       rb = ra >> $urandom_range(0, 31);
        default: rb = (i % 8 == 3) ? 32'd0 : $urandom;
      endcase
      run_op($sformatf("rand%0d", i), rm, ra, rb, model(rm, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
